dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Responder for the CPU data-memory port: accepts the CPU's load/store requests (enable, read/write strobes, byte address, store data and the eight size/sign flags) and services them against a word-wide single-port synchronous RAM. Handles byte/halfword stores by read-modify-write and byte/halfword loads by lane select plus sign/zero extension. Returns the load data and a one-cycle `dm_ready` acknowledge, which the CPU uses as its stall/advance condition.

## Interface
- `DEPTH`, 1024: RAM depth in 32-bit words; must be a power of two. `AW = $clog2(DEPTH)`.
- `BASE_ADDR`, 32'h1001_0000: byte address that maps to word 0.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `dm_ena`  in  1  request valid.
- `dm_r` / `dm_w`  in  1  read or write request.
- `dm_addr`  in  32  byte address.
- `dm_data_w`  in  32  store data; the byte or halfword sits in the low bits.
- `sb_flag`, `sh_flag`, `sw_flag`  in  1  store size.
- `lb_flag`, `lh_flag`, `lbu_flag`, `lhu_flag`, `lw_flag`  in  1  load size and sign.
- `dm_data`  out  32  formatted load data, registered.
- `dm_ready`  out  1  request complete, high for exactly one cycle.
- `dm_err`  out  1  misaligned access, valid with `dm_ready`. Constant 0 unless `DMEM_ALIGN_CHECK_EN` is defined.

## Operation
- Word index is `(dm_addr - BASE_ADDR)[AW+1:2]`. Out-of-range addresses wrap modulo `DEPTH`; this is not an error.
- Byte order is little-endian: lane k is bits `8k+7:8k`, selected by `addr[1:0]`. Halfword h is bits `16h+15:16h`, selected by `addr[1]`.
- FSM states: IDLE, LOAD, MERGE, ACK.
  - IDLE with `dm_ena & dm_w & sw`: capture the request, write the RAM on this edge, go to ACK.
  - IDLE with `dm_ena & dm_w & (sb|sh)`: capture the request, issue a RAM read, go to MERGE.
  - IDLE with `dm_ena & dm_r & !dm_w`: capture the request, issue a RAM read, go to LOAD.
  - IDLE with no request: stay in IDLE.
  - LOAD: format the RAM output into the `dm_data` register, go to ACK.
    - lb/lh: sign-extend.
    - lbu/lhu: zero-extend.
    - lw: full word.
  - MERGE: replace the addressed lane(s) of the RAM word with `dm_data_w[7:0]` or `dm_data_w[15:0]`, write it back, go to ACK.
  - ACK: `dm_ready = 1`, go to IDLE.
- Priority rules:
  - `dm_r` and `dm_w` both high: write wins.
  - Several size flags set: word > half > byte.
  - No size flag with `dm_ena`: treated as word.
- Request fields are captured in IDLE. Input changes after acceptance are ignored.
- `dm_data` changes only on the LOAD→ACK edge and holds until the next load completes. Stores do not modify it.

## Timing
- Reset values: state IDLE, `dm_ready` 0, `dm_data` 0, `dm_err` 0. RAM contents are not reset.
- Reset asserted mid-operation forces IDLE immediately. A pending MERGE write is abandoned and the RAM word is left unchanged.
- The RAM has a 1-cycle read: address presented on edge N, data valid during the cycle after N.
- Latency, counted from the accept edge to the cycle in which `dm_ready` is high:
  - sw: 1 cycle.
  - loads, sb, sh: 2 cycles.
- The CPU holds its request until it samples `dm_ready`. The block returns to IDLE after ACK, so back-to-back requests are accepted at most every 2 cycles (sw) or 3 cycles (others).
- A request presented during LOAD, MERGE or ACK is not sampled.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined: the following are misaligned.
  - lh, lhu or sh with `addr[0]=1`.
  - lw or sw with `addr[1:0]!=0`.
- Misaligned request response:
  - Go directly IDLE→ACK.
  - No RAM write.
  - `dm_data` loaded with 0.
  - `dm_err=1` for that ACK cycle.
- `DMEM_ALIGN_CHECK_EN` undefined: `addr[0]` is ignored for halfwords and `addr[1:0]` for words. `dm_err` is tied to 0.

## Structure
- Package `dmem_pkg`:
  - FSM state enum.
  - Size encoding (BYTE/HALF/WORD) and sign bit.
  - Default `BASE_ADDR`.
  - Pure functions `lane_extract` (load formatting) and `lane_merge` (store merging).
- Sub-module `dmem_ram`: single-port synchronous RAM, `DEPTH` x 32, one write enable, registered read. It is the only storage element besides the FSM and capture registers.

## Test plan
- Reset then sw 0x1001_0004 ← 0xDEADBEEF: `dm_ready` 1 cycle after accept. Then lw 0x1001_0004 → `dm_data` 0xDEADBEEF, `dm_ready` 2 cycles after accept.
- Word 0 = 0x11223344, then sb 0x1001_0002 ← 0x000000AA: word 0 reads 0x11AA3344 and all other lanes are unchanged.
- Word 1 = 0x80F0_7F01:
  - lb @+4 → 0x00000001.
  - lb @+6 → 0xFFFFFFF0.
  - lbu @+6 → 0x000000F0.
  - lh @+6 → 0xFFFF80F0.
  - lhu @+6 → 0x000080F0.
- sh 0x1001_0008 ← 0x1234 with reset asserted in the MERGE cycle: block returns to IDLE, `dm_ready`/`dm_data` are 0, and word 2 keeps its prior value.
- Address 0x1001_0000 + 4*DEPTH: write then read returns the value stored at word 0, confirming wrap-around.
- With `DMEM_ALIGN_CHECK_EN`, lw 0x1001_0002: `dm_ready` and `dm_err` are 1 together, `dm_data` is 0, RAM is unchanged. Without the macro, the same lw reads word 0 and `dm_err` is 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared types, constants and lane helpers for the data-memory
//           controller (FSM states, access size, load/store lane functions).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

   // Controller FSM states
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_MERGE = 2'd2,
      S_ACK   = 2'd3
   } state_t;

   // Access size
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

   // Select the addressed lane(s) of a RAM word and sign/zero extend them.
   function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input size_t       size,
                                                input logic        sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: res = {{24{sgn & b[7]}}, b};
         SZ_HALF: res = {{16{sgn & h[15]}}, h};
         default: res = word;
      endcase
      return res;
   endfunction

   // Replace the addressed lane(s) of a RAM word with the low store bits.
   function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input size_t       size,
                                              input logic [15:0] wd);
      logic [31:0] res;
      res = word;
      case (size)
         SZ_BYTE: res[{off, 3'b000} +: 8] = wd[7:0];
         SZ_HALF: begin
            if (off[1]) res[31:16] = wd;
            else        res[15:0]  = wd;
         end
         default: res = word;
      endcase
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_ram.sv
// ============================================================================
// Module  : dmem_ram
// Brief   : Single-port synchronous RAM, DEPTH x 32, one write enable,
//           registered read (data valid the cycle after the address edge).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] r_mem [DEPTH];

   // Write on enable; read port always registers the addressed word
   always_ff @(posedge clk) begin
      if (we) r_mem[addr] <= wdata;
      rdata <= r_mem[addr];
   end

endmodule

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ============================================================================
// Module  : dmem_ctrl
// Brief   : CPU data-memory responder. Word stores write directly, byte/half
//           stores use read-modify-write, loads are lane-selected and
//           sign/zero extended. One-cycle dm_ready acknowledge.
//           Optional misalignment detection: define DMEM_ALIGN_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dm_ena,
   input  logic        dm_r,
   input  logic        dm_w,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_data_w,
   input  logic        sb_flag,
   input  logic        sh_flag,
   input  logic        sw_flag,
   input  logic        lb_flag,
   input  logic        lh_flag,
   input  logic        lbu_flag,
   input  logic        lhu_flag,
   input  logic        lw_flag,
   output logic [31:0] dm_data,
   output logic        dm_ready,
   output logic        dm_err
);

   localparam int AW = $clog2(DEPTH);

   state_t        r_state, w_state_next;
   logic [AW-1:0] r_idx;
   logic [1:0]    r_off;
   size_t         r_size;
   logic          r_sgn;
   logic [15:0]   r_wdata;
   logic [31:0]   r_data;

   logic [AW-1:0] w_idx;
   size_t         w_st_size, w_ld_size, w_size;
   logic          w_ld_sgn, w_sgn;
   logic          w_accept, w_misalign;
   logic          w_ram_we;
   logic [AW-1:0] w_ram_addr;
   logic [31:0]   w_ram_wdata, w_ram_rdata;
   logic          w_unused_bits;

   // Word index relative to BASE_ADDR, wrapping modulo DEPTH (borrow from
   // the byte-offset bits keeps this exact for any base alignment)
   assign w_idx = dm_addr[AW+1:2] - BASE_ADDR[AW+1:2]
                - {{(AW-1){1'b0}}, (dm_addr[1:0] < BASE_ADDR[1:0])};
   assign w_unused_bits = ^{dm_addr[31:AW+2], dm_data_w[31:16]};

   // Size decode: word > half > byte, no flag means word
   always_comb begin
      w_st_size = SZ_WORD;
      w_ld_size = SZ_WORD;
      w_ld_sgn  = 1'b0;
      if (sw_flag)                 w_st_size = SZ_WORD;
      else if (sh_flag)            w_st_size = SZ_HALF;
      else if (sb_flag)            w_st_size = SZ_BYTE;
      if (lw_flag) begin
         w_ld_size = SZ_WORD;
      end else if (lh_flag | lhu_flag) begin
         w_ld_size = SZ_HALF;
         w_ld_sgn  = lh_flag;
      end else if (lb_flag | lbu_flag) begin
         w_ld_size = SZ_BYTE;
         w_ld_sgn  = lb_flag;
      end
   end

   assign w_size   = dm_w ? w_st_size : w_ld_size;
   assign w_sgn    = dm_w ? 1'b0 : w_ld_sgn;
   assign w_accept = (r_state == S_IDLE) && dm_ena && (dm_w || dm_r);

`ifdef DMEM_ALIGN_CHECK_EN
   logic r_err;

   assign w_misalign = ((w_size == SZ_HALF) && dm_addr[0])
                    || ((w_size == SZ_WORD) && (dm_addr[1:0] != 2'b00));

   // Remember whether the accepted request was misaligned
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          r_err <= 1'b0;
      else if (w_accept) r_err <= w_misalign;
   end

   assign dm_err = r_err && (r_state == S_ACK);
`else
   assign w_misalign = 1'b0;
   assign dm_err     = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_misalign)                  w_state_next = S_ACK;
               else if (dm_w && w_size == SZ_WORD) w_state_next = S_ACK;
               else if (dm_w)                   w_state_next = S_MERGE;
               else                             w_state_next = S_LOAD;
            end
         end
         S_LOAD:  w_state_next = S_ACK;
         S_MERGE: w_state_next = S_ACK;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Capture request fields at acceptance; later input changes are ignored
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx   <= '0;
         r_off   <= 2'b00;
         r_size  <= SZ_WORD;
         r_sgn   <= 1'b0;
         r_wdata <= 16'h0000;
      end else if (w_accept) begin
         r_idx   <= w_idx;
         r_off   <= dm_addr[1:0];
         r_size  <= w_size;
         r_sgn   <= w_sgn;
         r_wdata <= dm_data_w[15:0];
      end
   end

   // RAM port: live request in IDLE, captured index otherwise. Writes are
   // gated by reset so an abandoned merge never reaches the array.
   assign w_ram_addr  = (r_state == S_IDLE) ? w_idx : r_idx;
   assign w_ram_wdata = (r_state == S_IDLE) ? dm_data_w
                      : lane_merge(w_ram_rdata, r_off, r_size, r_wdata);
   assign w_ram_we    = rst && ((w_accept && dm_w && (w_size == SZ_WORD) && !w_misalign)
                             || (r_state == S_MERGE));

   dmem_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (w_ram_we),
      .addr  (w_ram_addr),
      .wdata (w_ram_wdata),
      .rdata (w_ram_rdata)
   );

   // Load data register: updated when a load completes or zeroed on error
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                         r_data <= 32'h0;
      else if (r_state == S_LOAD)       r_data <= lane_extract(w_ram_rdata, r_off, r_size, r_sgn);
      else if (w_accept && w_misalign)  r_data <= 32'h0;
   end

   assign dm_data  = r_data;
   assign dm_ready = (r_state == S_ACK);

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ============================================================================
// Module  : tb_dmem_ctrl
// Brief   : Directed self-checking bench for dmem_ctrl (stores, loads,
//           lane formatting, reset during merge, wrap-around, alignment).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_ctrl;

   localparam logic [31:0] BASE = 32'h1001_0000;
   localparam int          DEPTH = 1024;

   localparam logic [7:0] F_NONE = 8'h00;
   localparam logic [7:0] F_SB   = 8'h80;
   localparam logic [7:0] F_SH   = 8'h40;
   localparam logic [7:0] F_SW   = 8'h20;
   localparam logic [7:0] F_LB   = 8'h10;
   localparam logic [7:0] F_LH   = 8'h08;
   localparam logic [7:0] F_LBU  = 8'h04;
   localparam logic [7:0] F_LHU  = 8'h02;
   localparam logic [7:0] F_LW   = 8'h01;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        dm_ena = 1'b0, dm_r = 1'b0, dm_w = 1'b0;
   logic [31:0] dm_addr = '0, dm_data_w = '0;
   logic        sb_flag = 0, sh_flag = 0, sw_flag = 0;
   logic        lb_flag = 0, lh_flag = 0, lbu_flag = 0, lhu_flag = 0, lw_flag = 0;
   logic [31:0] dm_data;
   logic        dm_ready, dm_err;

   int n_checks = 0;
   int n_errors = 0;

   dmem_ctrl #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .dm_ena    (dm_ena),
      .dm_r      (dm_r),
      .dm_w      (dm_w),
      .dm_addr   (dm_addr),
      .dm_data_w (dm_data_w),
      .sb_flag   (sb_flag),
      .sh_flag   (sh_flag),
      .sw_flag   (sw_flag),
      .lb_flag   (lb_flag),
      .lh_flag   (lh_flag),
      .lbu_flag  (lbu_flag),
      .lhu_flag  (lhu_flag),
      .lw_flag   (lw_flag),
      .dm_data   (dm_data),
      .dm_ready  (dm_ready),
      .dm_err    (dm_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One CPU transaction: hold request until dm_ready, scrambling the data
   // and address inputs after acceptance to show they are not re-sampled.
   task automatic req(input logic w, input logic r, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [7:0] fl,
                      output logic [31:0] rd, output logic er, output int lat);
      @(negedge clk);
      dm_ena = 1'b1; dm_w = w; dm_r = r; dm_addr = addr; dm_data_w = wd;
      {sb_flag, sh_flag, sw_flag, lb_flag, lh_flag, lbu_flag, lhu_flag, lw_flag} = fl;
      lat = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         lat++;
         if (dm_ready) break;
         dm_addr   = $urandom;
         dm_data_w = $urandom;
      end
      if (!dm_ready) begin
         check("timeout", 32'd0, 32'd1);
         lat = 99;
      end
      rd = dm_data;
      er = dm_err;
      dm_ena = 1'b0; dm_w = 1'b0; dm_r = 1'b0;
      {sb_flag, sh_flag, sw_flag, lb_flag, lh_flag, lbu_flag, lhu_flag, lw_flag} = 8'h00;
      @(posedge clk); #1;
      check("ready_one_cycle", {31'd0, dm_ready}, 32'd0);
   endtask

   task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [7:0] fl, input int exp_lat);
      logic [31:0] rd;
      logic        er;
      int          lat;
      req(1'b1, 1'b0, addr, wd, fl, rd, er, lat);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_err"}, {31'd0, er}, 32'd0);
   endtask

   task automatic load(input string tag, input logic [31:0] addr, input logic [7:0] fl,
                       input logic [31:0] exp);
      logic [31:0] rd;
      logic        er;
      int          lat;
      req(1'b0, 1'b1, addr, 32'h0, fl, rd, er, lat);
      check({tag, "_data"}, rd, exp);
      check({tag, "_lat"}, lat, 32'd2);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, dm_ready}, 32'd0);
      check("rst_data",  dm_data, 32'd0);
      check("rst_err",   {31'd0, dm_err}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Word store then word load
      store("sw4", BASE + 32'h4, 32'hDEAD_BEEF, F_SW, 1);
      load ("lw4", BASE + 32'h4, F_LW, 32'hDEAD_BEEF);

      // Byte store merge; dm_data untouched by stores
      store("sw0", BASE, 32'h1122_3344, F_SW, 1);
      store("sb2", BASE + 32'h2, 32'hCCCC_CCAA, F_SB, 2);
      check("store_keeps_data", dm_data, 32'hDEAD_BEEF);
      load ("lw0_after_sb", BASE, F_LW, 32'h11AA_3344);

      // Load lane formatting
      store("sw_w1", BASE + 32'h4, 32'h80F0_7F01, F_SW, 1);
      load ("lb4",   BASE + 32'h4, F_LB,  32'h0000_0001);
      load ("lb5",   BASE + 32'h5, F_LB,  32'h0000_007F);
      load ("lb6",   BASE + 32'h6, F_LB,  32'hFFFF_FFF0);
      load ("lb7",   BASE + 32'h7, F_LB,  32'hFFFF_FF80);
      load ("lbu6",  BASE + 32'h6, F_LBU, 32'h0000_00F0);
      load ("lh6",   BASE + 32'h6, F_LH,  32'hFFFF_80F0);
      load ("lhu6",  BASE + 32'h6, F_LHU, 32'h0000_80F0);
      load ("lhu4",  BASE + 32'h4, F_LHU, 32'h0000_7F01);

      // Reset asserted during MERGE abandons the write
      store("sw_w2", BASE + 32'h8, 32'hCAFE_F00D, F_SW, 1);
      load ("lw_w2", BASE + 32'h8, F_LW, 32'hCAFE_F00D);
      @(negedge clk);
      dm_ena = 1'b1; dm_w = 1'b1; dm_addr = BASE + 32'h8; dm_data_w = 32'h0000_1234;
      sh_flag = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check("mrst_ready", {31'd0, dm_ready}, 32'd0);
      check("mrst_data",  dm_data, 32'd0);
      @(posedge clk);
      @(negedge clk);
      dm_ena = 1'b0; dm_w = 1'b0; sh_flag = 1'b0;
      rst = 1'b1;
      load ("lw_w2_kept", BASE + 32'h8, F_LW, 32'hCAFE_F00D);

      // Normal halfword store into the upper half
      store("sh_a", BASE + 32'hA, 32'hFFFF_1234, F_SH, 2);
      load ("lw_w2_sh", BASE + 32'h8, F_LW, 32'h1234_F00D);

      // Priority: write beats read, no size flag is word, half beats byte
      req(1'b1, 1'b1, BASE + 32'hC, 32'h5A5A_0F0F, F_NONE, rd, er, lat);
      check("rw_noflag_lat", lat, 32'd1);
      store("sbsh_e", BASE + 32'hE, 32'h0000_ABCD, F_SB | F_SH, 2);
      load ("lw_noflag", BASE + 32'hC, F_NONE, 32'hABCD_0F0F);

      // Wrap-around: one DEPTH past the base aliases word 0
      store("sw_wrap", BASE + 32'd4 * DEPTH, 32'h0BAD_F00D, F_SW, 1);
      load ("lw_wrap0", BASE, F_LW, 32'h0BAD_F00D);

      // Misaligned word load
      req(1'b0, 1'b1, BASE + 32'h2, 32'h0, F_LW, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
      check("mis_lw_lat",  lat, 32'd1);
      check("mis_lw_err",  {31'd0, er}, 32'd1);
      check("mis_lw_data", rd, 32'd0);
      store("sw_pre", BASE + 32'h10, 32'h7777_8888, F_SW, 1);
      req(1'b1, 1'b0, BASE + 32'h11, 32'h1111_2222, F_SW, rd, er, lat);
      check("mis_sw_err", {31'd0, er}, 32'd1);
      load ("mis_sw_kept", BASE + 32'h10, F_LW, 32'h7777_8888);
      load ("mis_lw_kept", BASE, F_LW, 32'h0BAD_F00D);
`else
      check("mis_lw_lat",  lat, 32'd2);
      check("mis_lw_err",  {31'd0, er}, 32'd0);
      check("mis_lw_data", rd, 32'h0BAD_F00D);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
